// File: rtl/ymat_row_fetch_ctrl.sv
// Y-matrix row fetch controller: round-robin arbitration of two row-index requesters, SRAM row read, entry slot extraction.
// Optional one-line reuse buffer enabled by defining YMR_LINE_REUSE_EN.
module ymat_row_fetch_ctrl #(
  parameter int RD_LAT  = 1,
  parameter int ENTRY_W = 32,
  parameter int ADDR_W  = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req0_valid,
  input  logic [ADDR_W+3:0]             req0_row,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [ADDR_W+3:0]             req1_row,
  output logic                          req1_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic signed [ENTRY_W/2-1:0]   rsp_real,
  output logic signed [ENTRY_W/2-1:0]   rsp_img,
  output logic                          sram_ce,
  output logic [ADDR_W-1:0]             sram_addr,
  input  logic [16*ENTRY_W-1:0]         sram_rdata,
  input  logic                          line_flush
);

  localparam int HALF = ENTRY_W / 2;
  localparam logic [1:0] WAIT_N = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [3:0]               lat_slot_q, lat_slot_d;
  logic                     lat_id_q, lat_id_d;
  logic signed [HALF-1:0]   real_q, real_d;
  logic signed [HALF-1:0]   img_q, img_d;

  logic                     grant, pick1;
  logic [ADDR_W+3:0]        gnt_row;
  logic [ENTRY_W-1:0]       entry;

`ifdef YMR_LINE_REUSE_EN
  logic [16*ENTRY_W-1:0]    line_q, line_d;
  logic [ADDR_W-1:0]        tag_q, tag_d;
  logic                     lvalid_q, lvalid_d;
  logic                     hit;
`else
  logic                     unused_line_flush;
  assign unused_line_flush = line_flush;
`endif

  function automatic logic [ENTRY_W-1:0] slot_entry(input logic [16*ENTRY_W-1:0] line,
                                                    input logic [3:0] slot);
    return line[slot*ENTRY_W +: ENTRY_W];
  endfunction

  function automatic logic signed [HALF-1:0] entry_real(input logic [ENTRY_W-1:0] e);
    return $signed(e[ENTRY_W-1:HALF]);
  endfunction

  function automatic logic signed [HALF-1:0] entry_img(input logic [ENTRY_W-1:0] e);
    return $signed(e[HALF-1:0]);
  endfunction

  // Round-robin: on a tie the requester not granted last time wins.
  assign pick1      = req1_valid && (!req0_valid || !last_grant_q);
  assign grant      = (state_q == S_IDLE) && !reset && (req0_valid || req1_valid);
  assign gnt_row    = pick1 ? req1_row : req0_row;
  assign req0_ready = grant && !pick1;
  assign req1_ready = grant && pick1;

  assign sram_ce    = (state_q == S_ISSUE);
  assign sram_addr  = addr_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = rsp_valid ? lat_id_q : 1'b0;
  assign rsp_real   = rsp_valid ? real_q : '0;
  assign rsp_img    = rsp_valid ? img_q : '0;

`ifdef YMR_LINE_REUSE_EN
  assign hit = lvalid_q && (tag_q == gnt_row[ADDR_W+3:4]) && !line_flush;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    lat_slot_d   = lat_slot_q;
    lat_id_d     = lat_id_q;
    real_d       = real_q;
    img_d        = img_q;
    entry        = slot_entry(sram_rdata, lat_slot_q);
`ifdef YMR_LINE_REUSE_EN
    line_d       = line_q;
    tag_d        = tag_q;
    lvalid_d     = lvalid_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          last_grant_d = pick1;
          lat_slot_d   = gnt_row[3:0];
          lat_id_d     = pick1;
`ifdef YMR_LINE_REUSE_EN
          if (hit) begin
            entry   = slot_entry(line_q, gnt_row[3:0]);
            real_d  = entry_real(entry);
            img_d   = entry_img(entry);
            state_d = S_RESP;
          end else begin
            addr_d  = gnt_row[ADDR_W+3:4];
            state_d = S_ISSUE;
          end
`else
          addr_d  = gnt_row[ADDR_W+3:4];
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        if (RD_LAT == 1) begin
          state_d = S_CAPT;
        end else begin
          cnt_d   = WAIT_N;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) state_d = S_CAPT;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_CAPT: begin
        real_d  = entry_real(entry);
        img_d   = entry_img(entry);
        state_d = S_RESP;
`ifdef YMR_LINE_REUSE_EN
        line_d   = sram_rdata;
        tag_d    = addr_q;
        lvalid_d = 1'b1;
`endif
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef YMR_LINE_REUSE_EN
    // A flush wins over a same-cycle fill.
    if (line_flush) lvalid_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      lat_slot_q   <= '0;
      lat_id_q     <= 1'b0;
`ifdef YMR_LINE_REUSE_EN
      lvalid_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      lat_slot_q   <= lat_slot_d;
      lat_id_q     <= lat_id_d;
`ifdef YMR_LINE_REUSE_EN
      lvalid_q     <= lvalid_d;
`endif
    end
  end

  // Data registers carry no reset; outputs are masked by rsp_valid.
  always_ff @(posedge clock) begin
    real_q <= real_d;
    img_q  <= img_d;
`ifdef YMR_LINE_REUSE_EN
    line_q <= line_d;
    tag_q  <= tag_d;
`endif
  end

endmodule
